// File: rtl/armleocpu_pkg.sv
// rtl/armleocpu_pkg.sv - opcode, ALU operation encodings and issue payload type for the ALU issue stage
package armleocpu_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

    localparam logic [6:0] FUNCT7_ZERO = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // {funct7, funct3} as seen by the ALU
    localparam logic [9:0] ALU_OP_ADD  = {7'b0000000, 3'b000};
    localparam logic [9:0] ALU_OP_SUB  = {7'b0100000, 3'b000};
    localparam logic [9:0] ALU_OP_SLL  = {7'b0000000, 3'b001};
    localparam logic [9:0] ALU_OP_SLT  = {7'b0000000, 3'b010};
    localparam logic [9:0] ALU_OP_SLTU = {7'b0000000, 3'b011};
    localparam logic [9:0] ALU_OP_XOR  = {7'b0000000, 3'b100};
    localparam logic [9:0] ALU_OP_SRL  = {7'b0000000, 3'b101};
    localparam logic [9:0] ALU_OP_SRA  = {7'b0100000, 3'b101};
    localparam logic [9:0] ALU_OP_OR   = {7'b0000000, 3'b110};
    localparam logic [9:0] ALU_OP_AND  = {7'b0000000, 3'b111};

    typedef struct packed {
        logic        is_alui;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] operand0;
        logic [31:0] alu_operand1;
        logic [31:0] alui_operand1;
        logic [4:0]  rd;
        logic        illegal;
    } alu_issue_t;

    function automatic logic is_base_alu_op(input logic [9:0] op);
        case (op)
            ALU_OP_ADD, ALU_OP_SUB, ALU_OP_SLL, ALU_OP_SLT, ALU_OP_SLTU,
            ALU_OP_XOR, ALU_OP_SRL, ALU_OP_SRA, ALU_OP_OR, ALU_OP_AND: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/armleocpu_skid_buffer.sv
// rtl/armleocpu_skid_buffer.sv - 2-entry registered skid buffer with flush, in_ready driven only by state
module armleocpu_skid_buffer
    import armleocpu_pkg::*;
#(
    parameter int WIDTH = $bits(alu_issue_t)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid;
    logic [WIDTH-1:0] main_data;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic             in_xfer;

    assign in_ready  = !skid_valid;
    assign in_xfer   = in_valid && !skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || out_ready) begin
            // skid is older than anything on the input, so it refills main first
            if (skid_valid) begin
                main_data  <= skid_data;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (in_xfer) begin
                main_data  <= in_data;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/armleocpu_alu_issue.sv
// rtl/armleocpu_alu_issue.sv - ALU decode/issue stage: decode, operand select, skid-buffered issue
// Optional write-back forwarding enabled by defining ARMLEOCPU_ALU_ISSUE_FORWARD_EN.
module armleocpu_alu_issue
    import armleocpu_pkg::*;
#(
    parameter int ILLEGAL_PASS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_rdata,
    input  logic [31:0] rs2_rdata,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_is_alui,
    output logic [2:0]  out_funct3,
    output logic [6:0]  out_funct7,
    output logic [31:0] out_operand0,
    output logic [31:0] out_alu_operand1,
    output logic [31:0] out_alui_operand1,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] shamt;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    alu_issue_t  dec;
    alu_issue_t  issue;
    logic        buf_in_valid;

    assign opcode   = in_instr[6:0];
    assign rd       = in_instr[11:7];
    assign funct3   = in_instr[14:12];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];
    assign funct7   = in_instr[31:25];
    assign shamt    = {27'b0, in_instr[24:20]};

`ifdef ARMLEOCPU_ALU_ISSUE_FORWARD_EN
    always_comb begin
        rs1_value = rs1_rdata;
        rs2_value = rs2_rdata;
        if (wb_valid && wb_rd == rs1_addr) rs1_value = wb_data;
        if (wb_valid && wb_rd == rs2_addr) rs2_value = wb_data;
        if (rs1_addr == 5'd0) rs1_value = 32'd0;
        if (rs2_addr == 5'd0) rs2_value = 32'd0;
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_rd, wb_data};

    assign rs1_value = (rs1_addr == 5'd0) ? 32'd0 : rs1_rdata;
    assign rs2_value = (rs2_addr == 5'd0) ? 32'd0 : rs2_rdata;
`endif

    always_comb begin
        dec         = '0;
        dec.is_alui = 1'b1;
        dec.illegal = 1'b1;
        case (opcode)
            OPCODE_OP: begin
                dec.is_alui      = 1'b0;
                dec.funct3       = funct3;
                dec.funct7       = funct7;
                dec.operand0     = rs1_value;
                dec.alu_operand1 = rs2_value;
                dec.rd           = rd;
                dec.illegal      = 1'b0;
            end
            OPCODE_OP_IMM: begin
                dec.funct3        = funct3;
                dec.operand0      = rs1_value;
                dec.alui_operand1 = {{20{in_instr[31]}}, in_instr[31:20]};
                dec.rd            = rd;
                dec.illegal       = 1'b0;
                if (funct3 == ALU_OP_SLL[2:0]) begin
                    dec.alui_operand1 = shamt;
                    dec.illegal       = (funct7 != FUNCT7_ZERO);
                end else if (funct3 == ALU_OP_SRL[2:0]) begin
                    dec.alui_operand1 = shamt;
                    // the ALU zeroes funct7 on the alui path, so SRAI goes down the register path
                    if ({funct7, funct3} == ALU_OP_SRA) begin
                        dec.is_alui       = 1'b0;
                        dec.funct7        = FUNCT7_ALT;
                        dec.alu_operand1  = shamt;
                        dec.alui_operand1 = 32'd0;
                    end else if (funct7 != FUNCT7_ZERO) begin
                        dec.illegal = 1'b1;
                    end
                end
            end
            OPCODE_LUI: begin
                dec.alui_operand1 = {in_instr[31:12], 12'b0};
                dec.rd            = rd;
                dec.illegal       = 1'b0;
            end
            OPCODE_AUIPC: begin
                dec.operand0      = in_pc;
                dec.alui_operand1 = {in_instr[31:12], 12'b0};
                dec.rd            = rd;
                dec.illegal       = 1'b0;
            end
            default: begin
                dec         = '0;
                dec.is_alui = 1'b1;
                dec.illegal = 1'b1;
            end
        endcase
    end

    // with ILLEGAL_PASS=0 an illegal word is still handshaken but never enters the buffer
    assign buf_in_valid = in_valid && ((ILLEGAL_PASS != 0) || !dec.illegal);

    armleocpu_skid_buffer #(
        .WIDTH($bits(alu_issue_t))
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (buf_in_valid),
        .in_ready  (in_ready),
        .in_data   (dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (issue)
    );

    assign out_is_alui       = issue.is_alui;
    assign out_funct3        = issue.funct3;
    assign out_funct7        = issue.funct7;
    assign out_operand0      = issue.operand0;
    assign out_alu_operand1  = issue.alu_operand1;
    assign out_alui_operand1 = issue.alui_operand1;
    assign out_rd            = issue.rd;
    assign out_illegal       = issue.illegal;

endmodule
